grf_scoreboard: RTL and testbench

- Tracks outstanding writes to the general register file: one pending-writer counter per architectural register.
- Incremented when a register-writing instruction issues from D; decremented when the write-back stage retires its write into grf.
- Reader side (D-stage operand fetch) queries rs/rt busy state and stalls until all pending writers retire.
- Sits beside grf, between issue logic and W-stage write port; it is the write-completion end of the grf write interface.

---
 rtl/grf_scoreboard.sv | 128 ++++++++++++
 tb/tb_grf_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// Pending-writer scoreboard for the general register file: one saturating counter per register.
// Define SCOREBOARD_WB_BYPASS_EN to clear busy in the same cycle the last pending write retires.
module grf_scoreboard #(
  parameter int REG_MAX = 32,
  parameter int CNT_W   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issueValid,
  input  logic [4:0] issueAddr,
  output logic       issueReady,
  input  logic       wbValid,
  input  logic [4:0] wbAddr,
  input  logic       flush,
  input  logic [4:0] rsAddr,
  input  logic [4:0] rtAddr,
  output logic       rsBusy,
  output logic       rtBusy,
  output logic       stall,
  output logic [7:0] pendingTotal,
  output logic       errUnderflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [REG_MAX];
  logic [CNT_W-1:0] cnt_d [REG_MAX];
  logic [7:0]       total_q, total_d;
  logic             err_q, err_d;

  logic             issue_acc_s, wb_acc_s, same_addr_s, inc_s, dec_s;
  logic [CNT_W-1:0] issue_cnt_s, wb_cnt_s, rs_cnt_s, rt_cnt_s;
  logic             rs_busy_s, rt_busy_s;

  // Issue acceptance and write-back qualification
  always_comb begin
    issue_cnt_s = cnt_q[issueAddr];
    wb_cnt_s    = cnt_q[wbAddr];
    wb_acc_s    = wbValid && (wbAddr != 5'd0);
    same_addr_s = wb_acc_s && (wbAddr == issueAddr);
    // A same-cycle retire to the issuing register frees a slot even when saturated.
    issueReady  = (issue_cnt_s != CNT_MAX) || same_addr_s;
    issue_acc_s = issueValid && issueReady && (issueAddr != 5'd0);
    inc_s       = issue_acc_s && !same_addr_s;
    dec_s       = wb_acc_s && !(issue_acc_s && same_addr_s) && (wb_cnt_s != '0);
  end

  // Next-state for counters, running total and sticky underflow flag
  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    err_d   = err_q;
    if (inc_s) begin
      cnt_d[issueAddr] = issue_cnt_s + CNT_ONE;
    end else begin
      cnt_d[issueAddr] = cnt_d[issueAddr];
    end
    if (dec_s) begin
      cnt_d[wbAddr] = wb_cnt_s - CNT_ONE;
    end else begin
      cnt_d[wbAddr] = cnt_d[wbAddr];
    end
    if (wb_acc_s && (wb_cnt_s == '0) && !(issue_acc_s && same_addr_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case ({inc_s, dec_s})
      2'b10:   total_d = total_q + 8'd1;
      2'b01:   total_d = total_q - 8'd1;
      default: total_d = total_q;
    endcase
    if (flush) begin
      for (int i = 0; i < REG_MAX; i++) begin
        cnt_d[i] = '0;
      end
      total_d = 8'd0;
    end else begin
      total_d = total_d;
    end
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_MAX; i++) begin
        cnt_q[i] <= '0;
      end
      total_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  // Operand busy query; register 0 always holds a zero count
  always_comb begin
    rs_cnt_s  = cnt_q[rsAddr];
    rt_cnt_s  = cnt_q[rtAddr];
    rs_busy_s = (rs_cnt_s != '0);
    rt_busy_s = (rt_cnt_s != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wbValid && (wbAddr == rsAddr) && (rs_cnt_s == CNT_ONE)) begin
      rs_busy_s = 1'b0;
    end else begin
      rs_busy_s = rs_busy_s;
    end
    if (wbValid && (wbAddr == rtAddr) && (rt_cnt_s == CNT_ONE)) begin
      rt_busy_s = 1'b0;
    end else begin
      rt_busy_s = rt_busy_s;
    end
`else
    rs_busy_s = rs_busy_s;
    rt_busy_s = rt_busy_s;
`endif
  end

  assign rsBusy       = rs_busy_s;
  assign rtBusy       = rt_busy_s;
  assign stall        = rs_busy_s || rt_busy_s || (issueValid && !issueReady);
  assign pendingTotal = total_q;
  assign errUnderflow = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: driver queues expected outputs, negedge monitor compares.
module tb_grf_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issueValid, wbValid, flush;
  logic [4:0] issueAddr, wbAddr, rsAddr, rtAddr;
  logic       issueReady, rsBusy, rtBusy, stall, errUnderflow;
  logic [7:0] pendingTotal;

  grf_scoreboard dut (
    .clk(clk), .reset(reset),
    .issueValid(issueValid), .issueAddr(issueAddr), .issueReady(issueReady),
    .wbValid(wbValid), .wbAddr(wbAddr), .flush(flush),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .rsBusy(rsBusy), .rtBusy(rtBusy),
    .stall(stall), .pendingTotal(pendingTotal), .errUnderflow(errUnderflow)
  );

  always #5 clk = ~clk;

  localparam int S_RS = 0, S_RT = 1, S_STALL = 2, S_RDY = 3, S_TOT = 4, S_ERR = 5;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] get_sig(input int sel);
    case (sel)
      S_RS:    return {7'd0, rsBusy};
      S_RT:    return {7'd0, rtBusy};
      S_STALL: return {7'd0, stall};
      S_RDY:   return {7'd0, issueReady};
      S_TOT:   return pendingTotal;
      default: return {7'd0, errUnderflow};
    endcase
  endfunction

  // Monitor: compare every expectation due at or before this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = get_sig(e.sel);
      n_checks++;
      if (e.cyc == cyc && act === e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_sig(input int sel, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    issueValid = 1'b0; issueAddr = 5'd0;
    wbValid = 1'b0; wbAddr = 5'd0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    step();
    issueValid = 1'b1; issueAddr = a;
  endtask

  task automatic wb(input logic [4:0] a);
    step();
    wbValid = 1'b1; wbAddr = a;
  endtask

  initial begin
    reset = 1'b1;
    issueValid = 1'b0; issueAddr = 5'd0; wbValid = 1'b0; wbAddr = 5'd0;
    flush = 1'b0; rsAddr = 5'd0; rtAddr = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Post-reset state
    step(); rsAddr = 5'd5; rtAddr = 5'd7;
    expect_sig(S_RS, 8'd0, "reset_rsBusy");
    expect_sig(S_RT, 8'd0, "reset_rtBusy");
    expect_sig(S_STALL, 8'd0, "reset_stall");
    expect_sig(S_RDY, 8'd1, "reset_issueReady");
    expect_sig(S_TOT, 8'd0, "reset_total");
    expect_sig(S_ERR, 8'd0, "reset_err");

    // Issue 5, busy one cycle later, retire it
    issue(5'd5);
    expect_sig(S_RS, 8'd0, "issue5_same_cycle_busy");
    expect_sig(S_RDY, 8'd1, "issue5_ready");
    step(); expect_sig(S_RS, 8'd1, "r5_busy"); expect_sig(S_STALL, 8'd1, "r5_stall");
    expect_sig(S_TOT, 8'd1, "r5_total");
    step(); expect_sig(S_RS, 8'd1, "r5_busy_hold");
    wb(5'd5); expect_sig(S_RS, {7'd0, ~BYP}, "r5_busy_wb_cycle");
    expect_sig(S_TOT, 8'd1, "r5_total_wb_cycle");
    step(); expect_sig(S_RS, 8'd0, "r5_clear"); expect_sig(S_TOT, 8'd0, "r5_total_zero");
    expect_sig(S_ERR, 8'd0, "r5_no_underflow");

    // Saturate register 9
    rsAddr = 5'd9;
    issue(5'd9); issue(5'd9); issue(5'd9);
    issue(5'd9);
    expect_sig(S_RDY, 8'd0, "r9_saturated_ready");
    expect_sig(S_STALL, 8'd1, "r9_saturated_stall");
    expect_sig(S_TOT, 8'd3, "r9_total3");
    issue(5'd9); wbValid = 1'b1; wbAddr = 5'd9;
    expect_sig(S_RDY, 8'd1, "r9_ready_with_wb");
    issue(5'd9);
    expect_sig(S_TOT, 8'd3, "r9_total_unchanged");
    expect_sig(S_RDY, 8'd0, "r9_still_saturated");
    expect_sig(S_RS, 8'd1, "r9_busy");
    wb(5'd9); wb(5'd9); wb(5'd9);
    step(); expect_sig(S_TOT, 8'd0, "r9_drained_total");
    expect_sig(S_RS, 8'd0, "r9_drained_busy");
    expect_sig(S_ERR, 8'd0, "r9_no_underflow");

    // Register 0 is never tracked
    rsAddr = 5'd0; rtAddr = 5'd0;
    for (int i = 0; i < 3; i++) begin
      issue(5'd0); wbValid = 1'b1; wbAddr = 5'd0;
      expect_sig(S_RS, 8'd0, "r0_busy");
      expect_sig(S_RDY, 8'd1, "r0_ready");
      expect_sig(S_STALL, 8'd0, "r0_stall");
    end
    wb(5'd0);
    step(); expect_sig(S_TOT, 8'd0, "r0_total"); expect_sig(S_ERR, 8'd0, "r0_no_underflow");

    // Underflow is sticky across flush
    wb(5'd12);
    expect_sig(S_ERR, 8'd0, "uf_not_yet");
    step(); expect_sig(S_ERR, 8'd1, "uf_set"); expect_sig(S_TOT, 8'd0, "uf_total");
    step(); flush = 1'b1;
    step(); expect_sig(S_ERR, 8'd1, "uf_after_flush");

    // Flush wins over a concurrent issue
    issue(5'd3); issue(5'd4); issue(5'd6);
    step(); rsAddr = 5'd3; rtAddr = 5'd4;
    expect_sig(S_TOT, 8'd3, "fl_total3");
    expect_sig(S_RS, 8'd1, "fl_r3_busy");
    expect_sig(S_RT, 8'd1, "fl_r4_busy");
    issue(5'd8); flush = 1'b1;
    step();
    expect_sig(S_RS, 8'd0, "fl_r3_clear"); expect_sig(S_RT, 8'd0, "fl_r4_clear");
    expect_sig(S_TOT, 8'd0, "fl_total0");
    step(); rsAddr = 5'd6; rtAddr = 5'd8;
    expect_sig(S_RS, 8'd0, "fl_r6_clear"); expect_sig(S_RT, 8'd0, "fl_r8_not_issued");

    // Independent issue and wb on different registers
    issue(5'd10);
    issue(5'd11); wbValid = 1'b1; wbAddr = 5'd10;
    step(); rsAddr = 5'd10; rtAddr = 5'd11;
    expect_sig(S_RS, 8'd0, "diff_r10_clear"); expect_sig(S_RT, 8'd1, "diff_r11_busy");
    expect_sig(S_TOT, 8'd1, "diff_total1");

    // Asynchronous reset mid-cycle, checked before any further clock edge
    step(); rsAddr = 5'd11; rtAddr = 5'd11; issueValid = 1'b1; issueAddr = 5'd9;
    #1 reset = 1'b1;
    expect_sig(S_RS, 8'd0, "areset_busy");
    expect_sig(S_TOT, 8'd0, "areset_total");
    expect_sig(S_ERR, 8'd0, "areset_err");
    expect_sig(S_RDY, 8'd1, "areset_ready");
    expect_sig(S_STALL, 8'd0, "areset_stall");

    step(); step();
    if (q.size() != 0) begin
      n_checks += q.size();
      $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
